alu_muldiv_control: RTL and testbench



---
 rtl/alu_muldiv_control_pkg.sv | 56 +++++
 rtl/alu_muldiv_control_muldiv_iter.sv | 98 +++++++++
 rtl/alu_muldiv_control.sv | 123 ++++++++++++
 tb/tb_alu_muldiv_control.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_control_pkg.sv
// Shared encodings for the execute-stage ALU control decoder and the
// iterative multiply/divide sequencer.
package alu_muldiv_control_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } md_state_t;

    // funct7[5] only selects SUB for register-register ops; immediates always add.
    function automatic logic [3:0] alu_func_code(input logic [2:0] f3,
                                                 input logic       alt,
                                                 input logic       is_rtype);
        case (f3)
            3'b000:  alu_func_code = (alt && is_rtype) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_func_code = ALU_SLL;
            3'b010:  alu_func_code = ALU_SLT;
            3'b011:  alu_func_code = ALU_SLTU;
            3'b100:  alu_func_code = ALU_XOR;
            3'b101:  alu_func_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_func_code = ALU_OR;
            default: alu_func_code = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_muldiv_control_muldiv_iter.sv
// Radix-2 multiply/divide datapath: magnitude accumulator stepped by the
// sequencer, with sign fix-up folded into the final step.
import alu_muldiv_control_pkg::*;

module alu_muldiv_control_muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_step,
    input  logic            i_finish,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_op_a,
    input  logic [XLEN-1:0] i_op_b,
    output logic            o_special,
    output logic [XLEN-1:0] o_result
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_mag_b;
    logic              r_is_div;
    logic              r_sel_upper;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;

    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_special_result;

    assign w_is_div   = i_funct3[2];
    assign w_a_signed = w_is_div ? !i_funct3[0] : (i_funct3 == F3_MULH || i_funct3 == F3_MULHSU);
    assign w_b_signed = w_is_div ? !i_funct3[0] : (i_funct3 == F3_MULH);
    assign w_sa       = w_a_signed && i_op_a[XLEN-1];
    assign w_sb       = w_b_signed && i_op_b[XLEN-1];
    assign w_mag_a    = w_sa ? -i_op_a : i_op_a;
    assign w_mag_b    = w_sb ? -i_op_b : i_op_b;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign o_special = w_is_div && ((i_op_b == '0) ||
                       (!i_funct3[0] && i_op_a == MOST_NEG && i_op_b == '1));
    assign w_special_result = (i_op_b == '0) ? (i_funct3[1] ? i_op_a : '1)
                                             : (i_funct3[1] ? '0 : i_op_a);

    // Multiply: conditional add into the upper half, then shift right.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_mag_b} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide: {remainder, quotient} shifted left, trial subtract restores on borrow.
    logic [XLEN:0]     w_rem_sh, w_diff;
    logic              w_qbit;
    logic [2*XLEN-1:0] w_div_next;
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_mag_b};
    assign w_qbit     = !w_diff[XLEN];
    assign w_div_next = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_qbit};

    logic [2*XLEN-1:0] w_acc_next, w_prod_fix;
    logic [XLEN-1:0]   w_div_part, w_final;
    assign w_acc_next = r_is_div ? w_div_next : w_mul_next;
    assign w_prod_fix = r_neg ? -w_mul_next : w_mul_next;
    assign w_div_part = r_sel_upper ? w_div_next[2*XLEN-1:XLEN] : w_div_next[XLEN-1:0];
    assign w_final    = r_is_div ? (r_neg ? -w_div_part : w_div_part)
                                 : (r_sel_upper ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_mag_b     <= '0;
            r_is_div    <= 1'b0;
            r_sel_upper <= 1'b0;
            r_neg       <= 1'b0;
            r_result    <= '0;
        end else if (i_start) begin
            r_acc       <= {{XLEN{1'b0}}, w_mag_a};
            r_mag_b     <= w_mag_b;
            r_is_div    <= w_is_div;
            r_sel_upper <= w_is_div ? i_funct3[1] : (i_funct3 != F3_MUL);
            r_neg       <= (w_is_div && i_funct3[1]) ? w_sa : (w_sa ^ w_sb);
            if (o_special) begin
                r_result <= w_special_result;
            end
        end else if (i_step || i_finish) begin
            r_acc <= w_acc_next;
            if (i_finish) begin
                r_result <= w_final;
            end
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/alu_muldiv_control.sv
// Execute-stage ALU control decoder plus the handshake FSM that sequences
// the iterative M-extension multiply/divide unit.
import alu_muldiv_control_pkg::*;

module alu_muldiv_control #(
    parameter int XLEN     = 64,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [3:0]      alu_control_signal,
    output logic            illegal,
    output logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] md_result
);

    localparam int CW = $clog2(XLEN + 1);

    logic [3:0] w_alu_code;
    logic       w_illegal, w_f7_std, w_m_op;

    assign w_f7_std = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
    assign w_m_op   = ENABLE_M && (alu_op == ALUOP_RTYPE) && (funct7 == FUNCT7_MULDIV);

    always_comb begin
        w_alu_code = ALU_ADD;
        w_illegal  = 1'b0;
        case (alu_op)
            ALUOP_MEM: w_alu_code = ALU_ADD;
            ALUOP_BR:  w_alu_code = ALU_SUB;
            ALUOP_RTYPE: begin
                if (w_f7_std) begin
                    w_alu_code = alu_func_code(funct3, funct7[5], 1'b1);
                end else if (funct7 == FUNCT7_MULDIV) begin
                    w_illegal = !ENABLE_M;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_alu_code = alu_func_code(funct3, funct7[5], 1'b0);
        endcase
    end

    assign alu_control_signal = w_alu_code;
    assign illegal            = w_illegal;

    md_state_t     r_state;
    logic [CW-1:0] r_cnt;
    logic          r_in_ready, r_out_valid;
    logic          w_start, w_step, w_finish, w_special;

    assign w_start  = !flush && (r_state == ST_IDLE) && in_valid && w_m_op;
    assign w_step   = !flush && (r_state == ST_BUSY) && (r_cnt != CW'(1));
    assign w_finish = !flush && (r_state == ST_BUSY) && (r_cnt == CW'(1));

    // flush outranks both the DONE handshake and a fresh accept.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_in_ready <= 1'b0;
                        if (w_special) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CW'(XLEN);
                        end
                    end
                end
                ST_BUSY: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign stall     = ((r_state != ST_IDLE) && !((r_state == ST_DONE) && out_ready)) ||
                       ((r_state == ST_IDLE) && in_valid && w_m_op);

    alu_muldiv_control_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_step    (w_step),
        .i_finish  (w_finish),
        .i_funct3  (funct3),
        .i_op_a    (op_a),
        .i_op_b    (op_b),
        .o_special (w_special),
        .o_result  (md_result)
    );

endmodule

// File: tb/tb_alu_muldiv_control.sv
// Directed bench for alu_muldiv_control: decode vectors, M-op results and
// latency, DONE hold, flush, mid-op reset and an ENABLE_M=0 build.
module tb_alu_muldiv_control;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, flush, out_ready;
    logic [1:0]  alu_op;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;

    logic        in_ready, illegal, stall, out_valid;
    logic [3:0]  alu_control_signal;
    logic [63:0] md_result;
    logic        in_ready_n, illegal_n, stall_n, out_valid_n;
    logic [3:0]  alu_control_signal_n;
    logic [63:0] md_result_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_muldiv_control #(.XLEN(64), .ENABLE_M(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .in_valid(in_valid), .in_ready(in_ready), .op_a(op_a), .op_b(op_b),
        .flush(flush), .alu_control_signal(alu_control_signal), .illegal(illegal),
        .stall(stall), .out_valid(out_valid), .out_ready(out_ready), .md_result(md_result)
    );

    alu_muldiv_control #(.XLEN(64), .ENABLE_M(1'b0)) u_dut_nom (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
        .in_valid(in_valid), .in_ready(in_ready_n), .op_a(op_a), .op_b(op_b),
        .flush(flush), .alu_control_signal(alu_control_signal_n), .illegal(illegal_n),
        .stall(stall_n), .out_valid(out_valid_n), .out_ready(out_ready), .md_result(md_result_n)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                       input logic [3:0] code, input logic ill);
        alu_op = aop; funct7 = f7; funct3 = f3; in_valid = 1'b0;
        #1;
        $display("dec alu_op=%b funct7=%b funct3=%b -> code=%b illegal=%b",
                 aop, f7, f3, alu_control_signal, illegal);
        check($sformatf("dec_code_%b_%b_%b", aop, f7, f3), 64'(alu_control_signal), 64'(code));
        check($sformatf("dec_ill_%b_%b_%b", aop, f7, f3), 64'(illegal), 64'(ill));
    endtask

    // Drive one M op into IDLE; the next edge is the accept edge.
    task automatic issue(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b);
        alu_op = 2'b10; funct7 = 7'b0000001; funct3 = f3;
        op_a = a; op_b = b; in_valid = 1'b1;
    endtask

    task automatic run_md(input string name, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                          input bit hold);
        int   lat;
        logic busy_ok;
        issue(f3, a, b);
        out_ready = 1'b0;
        #1;
        check({name, "_accept_stall"}, 64'(stall), 64'd1);
        tick();
        in_valid = 1'b0; op_a = '0; op_b = '0; funct3 = 3'b000;
        lat = 0; busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!stall || in_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        $display("md %s f3=%b a=0x%0h b=0x%0h -> 0x%0h after %0d cycles", name, f3, a, b, md_result, lat);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_busy_stall"}, 64'(busy_ok), 64'd1);
        check({name, "_result"}, md_result, exp);
        if (hold) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check({name, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({name, "_hold_result"}, md_result, exp);
                check({name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
                check({name, "_hold_stall"}, 64'(stall), 64'd1);
            end
        end
        out_ready = 1'b1;
        #1;
        check({name, "_release_stall"}, 64'(stall), 64'd0);
        tick();
        out_ready = 1'b0;
        check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
        check({name, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        alu_op = 2'b00; funct7 = '0; funct3 = '0; op_a = '0; op_b = '0;
        tick(); tick();
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_md_result", md_result, 64'd0);
        check("reset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1;
        tick();

        dec(2'b00, 7'b1111111, 3'b111, 4'b0010, 1'b0);
        dec(2'b01, 7'b0000000, 3'b000, 4'b0110, 1'b0);
        dec(2'b10, 7'b0000000, 3'b000, 4'b0010, 1'b0);
        dec(2'b10, 7'b0100000, 3'b000, 4'b0110, 1'b0);
        dec(2'b10, 7'b0000000, 3'b001, 4'b0100, 1'b0);
        dec(2'b10, 7'b0000000, 3'b010, 4'b1000, 1'b0);
        dec(2'b10, 7'b0000000, 3'b011, 4'b1001, 1'b0);
        dec(2'b10, 7'b0000000, 3'b100, 4'b0011, 1'b0);
        dec(2'b10, 7'b0000000, 3'b101, 4'b0101, 1'b0);
        dec(2'b10, 7'b0100000, 3'b101, 4'b0111, 1'b0);
        dec(2'b10, 7'b0000000, 3'b110, 4'b0001, 1'b0);
        dec(2'b10, 7'b0000000, 3'b111, 4'b0000, 1'b0);
        dec(2'b11, 7'b0100000, 3'b000, 4'b0010, 1'b0);
        dec(2'b11, 7'b0000000, 3'b010, 4'b1000, 1'b0);
        dec(2'b11, 7'b0000000, 3'b101, 4'b0101, 1'b0);
        dec(2'b11, 7'b0100000, 3'b101, 4'b0111, 1'b0);
        dec(2'b11, 7'b0000000, 3'b111, 4'b0000, 1'b0);
        dec(2'b10, 7'b1111111, 3'b000, 4'b0010, 1'b1);
        dec(2'b10, 7'b0000001, 3'b000, 4'b0010, 1'b0);
        dec(2'b10, 7'b0000001, 3'b110, 4'b0010, 1'b0);

        run_md("mul",    3'b000, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1);
        run_md("mulhu",  3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 64, 1'b0);
        run_md("mulh",   3'b001, -64'sd1, -64'sd1, 64'd0, 64, 1'b0);
        run_md("mulhsu", 3'b010, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run_md("div",    3'b100, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b0);
        run_md("rem",    3'b110, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b0);
        run_md("remu",   3'b111, 64'd100, 64'd7, 64'd2, 64, 1'b0);
        run_md("divu0",  3'b101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        run_md("rem0",   3'b110, 64'd9, 64'd0, 64'd9, 0, 1'b0);
        run_md("removf", 3'b110, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 0, 1'b0);
        run_md("divovf", 3'b100, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 0, 1'b1);

        // A request presented during the DONE handshake must wait for IDLE.
        issue(3'b101, 64'd5, 64'd0);
        tick();
        issue(3'b111, 64'd6, 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("b2b_no_same_edge_accept", 64'(in_ready), 64'd1);
        check("b2b_no_same_edge_valid", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        check("b2b_second_valid", 64'(out_valid), 64'd1);
        check("b2b_second_result", md_result, 64'd6);
        $display("b2b remu 6/0 -> 0x%0h", md_result);
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Flush ten cycles into BUSY.
        issue(3'b000, 64'd3, 64'd5);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_stall", 64'(stall), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        $display("flush mul 3*5 at busy cycle 10 -> out_valid seen=%0d", seen);
        check("flush_no_out_valid", 64'(seen), 64'd0);

        // Reset asserted mid-operation.
        issue(3'b000, 64'd3, 64'd5);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0; tick();
        $display("reset mid-op -> in_ready=%0d out_valid=%0d md_result=0x%0h", in_ready, out_valid, md_result);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_md_result", md_result, 64'd0);
        check("midreset_stall", 64'(stall), 64'd0);
        rst_n = 1'b1; tick();

        // ENABLE_M=0 build treats the M encoding as illegal and never starts.
        issue(3'b000, 64'd7, 64'd3);
        #1;
        check("nom_illegal", 64'(illegal_n), 64'd1);
        check("nom_stall", 64'(stall_n), 64'd0);
        tick();
        in_valid = 1'b0;
        $display("nom mul -> illegal=%0d in_ready=%0d out_valid=%0d", illegal_n, in_ready_n, out_valid_n);
        check("nom_in_ready", 64'(in_ready_n), 64'd1);
        repeat (70) tick();
        check("nom_out_valid", 64'(out_valid_n), 64'd0);
        out_ready = 1'b1; repeat (70) tick(); out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
